// File: rtl/alu_result_stage.sv
// alu_result_stage: 2-entry skid FIFO after the ALU with a conditional flags register.
// Define ALU_RESULT_STAGE_COND_EN to evaluate Cond and gate flag writes on it.
module alu_result_stage #(
    parameter int SIZE = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] Result,
    input  logic [3:0]      ALUFlags,
    input  logic            FlagWrite,
    input  logic [3:0]      Cond,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_result,
    output logic            out_condex,
    output logic [3:0]      out_flags,
    output logic [3:0]      flags_q
);
    typedef struct packed {
        logic [SIZE-1:0] res;
        logic            condex;
        logic [3:0]      flags;
    } entry_t;

    entry_t     mem_q [2];
    entry_t     mem_d [2];
    logic [1:0] cnt_q, cnt_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic       rdy_q;
    logic [3:0] flags_d;
    logic       condex, push, pop;

`ifdef ALU_RESULT_STAGE_COND_EN
    logic n, z, c, v, base;
    always_comb begin
        {n, z, c, v} = flags_q;
        base = (Cond[3:1] == 3'd0) ? z :
               (Cond[3:1] == 3'd1) ? c :
               (Cond[3:1] == 3'd2) ? n :
               (Cond[3:1] == 3'd3) ? v :
               (Cond[3:1] == 3'd4) ? (c & !z) :
               (Cond[3:1] == 3'd5) ? (n == v) :
               (Cond[3:1] == 3'd6) ? (!z & (n == v)) : 1'b1;
        // odd codes are the complement of the even one, except 111x which always passes
        condex = (&Cond[3:1]) ? 1'b1 : base ^ Cond[0];
    end
`else
    logic unused_cond;
    assign unused_cond = ^Cond;
    assign condex = 1'b1;
`endif

    // in_ready only looks at registered state, so it stays low until the first edge after reset
    assign in_ready   = rdy_q & (cnt_q != 2'd2);
    assign out_valid  = (cnt_q != 2'd0);
    assign out_result = mem_q[rd_ptr_q].res;
    assign out_condex = mem_q[rd_ptr_q].condex;
    assign out_flags  = mem_q[rd_ptr_q].flags;
    assign push       = in_valid & in_ready;
    assign pop        = out_valid & out_ready;

    always_comb begin
        mem_d    = mem_q;
        flags_d  = (push & FlagWrite & condex) ? ALUFlags : flags_q;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
        if (push) mem_d[wr_ptr_q] = '{res: Result, condex: condex, flags: flags_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            cnt_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            rdy_q    <= 1'b0;
            flags_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rdy_q    <= 1'b1;
            flags_q  <= flags_d;
        end
    end
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: scoreboard bench for alu_result_stage; the driver queues expected
// entries on each accept and a monitor checks them as the DUT hands them downstream.
module tb_alu_result_stage;
    localparam int SIZE = 16;
`ifdef ALU_RESULT_STAGE_COND_EN
    localparam bit COND = 1'b1;
`else
    localparam bit COND = 1'b0;
`endif

    logic            clk = 1'b0, rst_n = 1'b0;
    logic            in_valid = 1'b0, in_ready, FlagWrite = 1'b0;
    logic            out_valid, out_ready = 1'b0, out_condex;
    logic [SIZE-1:0] Result = '0, out_result;
    logic [3:0]      ALUFlags = '0, Cond = '0, out_flags, flags_q;
    int              tests = 0, fails = 0;
    logic [SIZE+4:0] sbq[$];
    logic [SIZE+4:0] e;
    logic [3:0]      mflags = '0;

    always #5 clk = ~clk;

    alu_result_stage #(.SIZE(SIZE)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .Result(Result), .ALUFlags(ALUFlags), .FlagWrite(FlagWrite), .Cond(Cond),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_condex(out_condex), .out_flags(out_flags), .flags_q(flags_q)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic cond_ok(input logic [3:0] f, input logic [3:0] c);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    task automatic send(input logic [SIZE-1:0] r, input logic [3:0] af, input logic fw,
                        input logic [3:0] c);
        int  g = 0;
        logic pass;
        in_valid = 1'b1; Result = r; ALUFlags = af; FlagWrite = fw; Cond = c;
        @(negedge clk);
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) chk("accept_timeout", in_ready, 1);
        else begin
            pass = COND ? cond_ok(mflags, c) : 1'b1;
            if (fw && pass) mflags = af;
            sbq.push_back({r, pass, mflags});
        end
        @(posedge clk); #1;
        in_valid = 1'b0; Result = '1; ALUFlags = 4'hF; FlagWrite = 1'b1; Cond = 4'hE;
    endtask

    task automatic drain();
        int g = 0;
        while (out_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("drain", out_valid, 0);
        @(posedge clk); #1;
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
            if (sbq.size() == 0) chk("unexpected_output", out_valid, 0);
            else begin
                e = sbq.pop_front();
                chk("out_result", out_result, e[SIZE+4:5]);
                chk("out_condex", out_condex, e[4]);
                chk("out_flags", out_flags, e[3:0]);
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_flags_q", flags_q, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_condex", out_condex, 0);
        chk("rst_out_flags", out_flags, 0);
        rst_n = 1'b1;
        #1 chk("ready_before_edge", in_ready, 0);
        @(posedge clk); #1;
        chk("ready_after_edge", in_ready, 1);
        out_ready = 1'b1;

        send(16'h1234, 4'b0000, 1'b1, 4'hE);
        chk("lat_out_valid", out_valid, 1);
        chk("lat_out_result", out_result, 16'h1234);
        chk("lat_out_condex", out_condex, 1);
        chk("lat_flags_q", flags_q, 4'b0000);

        send(16'h0001, 4'b0100, 1'b1, 4'hE);
        chk("set_flags", flags_q, 4'b0100);
        send(16'h0002, 4'b1000, 1'b1, 4'h1);
        chk("ne_condex", out_condex, COND ? 0 : 1);
        chk("ne_flags_q", flags_q, COND ? 4'b0100 : 4'b1000);
        send(16'h0003, 4'b0000, 1'b0, 4'h0);
        chk("eq_condex", out_condex, 1);

        send(16'h0004, 4'b0000, 1'b1, 4'hE);
        send(16'h0005, 4'b0010, 1'b1, 4'h0);
        chk("eqz0_condex", out_condex, COND ? 0 : 1);
        chk("eqz0_flags_q", flags_q, COND ? 4'b0000 : 4'b0010);
        repeat (3) @(posedge clk);
        #1 chk("idle_flags_hold", flags_q, COND ? 4'b0000 : 4'b0010);

        foreach (sbq[i]) begin end
        for (int k = 0; k < 3; k++) begin
            logic [3:0] f;
            f = (k == 0) ? 4'b1001 : (k == 1) ? 4'b0110 : 4'b0010;
            send(16'h0100 + 16'(k), f, 1'b1, 4'hE);
            for (int c = 0; c < 16; c++) send(16'h0200 + 16'(k * 16 + c), 4'b1111, 1'b0, 4'(c));
        end

        drain();
        out_ready = 1'b0;
        send(16'h0001, 4'b0000, 1'b0, 4'hE);
        send(16'h0002, 4'b0000, 1'b0, 4'hE);
        chk("full_in_ready", in_ready, 0);
        fork
            send(16'h0003, 4'b0000, 1'b0, 4'hE);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("hold_head", out_result, 16'h0001);
                    chk("hold_in_ready", in_ready, 0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join

        drain();
        fork
            for (int i = 0; i < 20; i++) send(16'h0300 + 16'(i), 4'(i), 1'b1, 4'hE);
            begin
                int g = 0;
                while (!out_valid && g < 10) begin
                    @(negedge clk);
                    g++;
                end
                for (int i = 0; i < 20; i++) begin
                    chk("no_bubble", out_valid, 1);
                    @(negedge clk);
                end
            end
        join

        drain();
        out_ready = 1'b0;
        send(16'hAAAA, 4'hF, 1'b1, 4'hE);
        send(16'hBBBB, 4'h5, 1'b1, 4'hE);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_flags_q", flags_q, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_out_result", out_result, 0);
        sbq.delete();
        mflags = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(16'h5A5A, 4'h3, 1'b1, 4'hE);
        chk("post_rst_flags", flags_q, 4'h3);
        drain();
        chk("scoreboard_empty", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL have parameter SIZE, default 16, datapath width; it matches the upstream ALU SIZE.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream ALU result present this cycle.
REQ-005 SHALL have port in_ready  output  1  stage can accept an entry this cycle.
REQ-006 SHALL have port Result  input  SIZE  ALU result.
REQ-007 SHALL have port ALUFlags  input  4  ALU flags: [3]=N, [2]=Z, [1]=C, [0]=V.
REQ-008 SHALL have port FlagWrite  input  1  request to commit ALUFlags into the flags register.
REQ-009 SHALL have port Cond  input  4  condition code for this operation.
REQ-010 SHALL have port out_valid  output  1  head entry valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the head entry.
REQ-012 SHALL have port out_result  output  SIZE  head entry result.
REQ-013 SHALL have port out_condex  output  1  head entry condition-passed bit.
REQ-014 SHALL have port out_flags  output  4  head entry flags snapshot (flags register value after this op).
REQ-015 SHALL have port flags_q  output  4  live architectural flags register.

Function
REQ-016 SHALL implement a 2-entry FIFO skid buffer; in_ready = (count < 2), derived from registered state only, never from out_ready.
REQ-017 Accept SHALL occur when in_valid & in_ready; pop SHALL occur when out_valid & out_ready.
REQ-018 Latency SHALL be one cycle: an entry accepted into an empty buffer presents out_valid=1 on the next cycle.
REQ-019 Simultaneous accept and pop SHALL leave count unchanged and preserve FIFO order; this is legal only at count=1.
REQ-020 The FIFO SHALL hold out_result/out_condex/out_flags stable while out_valid=1 and out_ready=0.
REQ-021 Condition evaluation SHALL use flags_q before this op's update, as N,Z,C,V:
- 0000 EQ: Z; 0001 NE: !Z
- 0010 CS: C; 0011 CC: !C
- 0100 MI: N; 0101 PL: !N
- 0110 VS: V; 0111 VC: !V
- 1000 HI: C&!Z; 1001 LS: !C|Z
- 1010 GE: N==V; 1011 LT: N!=V
- 1100 GT: !Z&(N==V); 1101 LE: Z|(N!=V)
- 1110 AL: 1; 1111: 1
REQ-022 On accept, flags_q SHALL load ALUFlags iff FlagWrite & condex; otherwise flags_q SHALL hold.
REQ-023 Each stored entry's out_flags SHALL equal the flags_q value after that accept's update.
REQ-024 Back-to-back accepts SHALL chain: the second op's condition sees the first op's committed flags.
REQ-025 Inputs SHALL be ignored in any cycle without an accept, including FlagWrite.
REQ-026 Entries with condex=0 SHALL still be enqueued and delivered, with out_condex=0; the consumer squashes them.
REQ-027 Pointer wrap from entry 1 to entry 0 SHALL be seamless, with no bubble.

Reset
REQ-028 While rst_n=0: count=0, pointers=0, out_valid=0, in_ready=0, flags_q=4'b0000, out_result=0, out_condex=0, out_flags=0.
REQ-029 Reset asserted mid-operation SHALL discard all buffered entries immediately and asynchronously.
REQ-030 in_ready SHALL rise on the first clk edge after rst_n deasserts.

Configuration
REQ-031 With ALU_RESULT_STAGE_COND_EN defined: Cond SHALL be evaluated per REQ-021 and gate flag writes per REQ-022.
REQ-032 Without ALU_RESULT_STAGE_COND_EN: Cond SHALL be ignored, condex SHALL be 1 for every entry, and flags_q SHALL load on accept & FlagWrite.

Verification
REQ-033 Reset, then accept Result=16'h1234, ALUFlags=4'b0000, FlagWrite=1, Cond=1110 -> next cycle out_valid=1, out_result=16'h1234, out_condex=1, flags_q=0000.
REQ-034 With flags_q=4'b0100, accept Cond=0001 (NE), FlagWrite=1, ALUFlags=4'b1000 -> out_condex=0 and flags_q stays 0100; then a Cond=0000 (EQ) op -> out_condex=1.
REQ-035 Hold out_ready=0 and push 3 ops -> in_ready=0 after the 2nd accept, the 3rd is held upstream, and the head stays stable; release out_ready -> values 1,2,3 delivered in order.
REQ-036 Steady in_valid=1 and out_ready=1 for 20 cycles -> one entry per cycle with no bubbles across pointer wrap.
REQ-037 Assert rst_n=0 with 2 entries buffered -> out_valid=0 and flags_q=0 immediately, without waiting for a clk edge.
REQ-038 Build without ALU_RESULT_STAGE_COND_EN, accept Cond=0000 with Z=0, FlagWrite=1, ALUFlags=4'b0010 -> out_condex=1 and flags_q=0010.
